// File: rtl/div.sv
// Sequential unsigned restoring divider, 16/8 -> 16-bit quotient, 8-bit remainder, one bit per clock.
// Latency 16 cycles from accept to done; start is accepted only while ready, otherwise ignored (no queueing).
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] a,
    input  logic [7:0]  b,
    output logic        ready,
    output logic        busy,
    output logic        done,
    output logic [15:0] q,
    output logic [7:0]  r,
    output logic        dbz
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] WORK = 1'b1;

    logic [0:0]  state;
    logic [3:0]  cnt;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic [7:0]  rem;
    logic [15:0] quo;
    logic        zdiv;

    logic [8:0]  rem_t;
    logic        ge;
    logic [7:0]  rem_nx;
    logic [15:0] quo_nx;

    // The stored remainder is always < divisor, so only the trial value needs the ninth bit.
    always_comb begin
        rem_t  = {rem, dividend[15]};
        ge     = (rem_t >= {1'b0, divisor});
        rem_nx = ge ? 8'(rem_t - {1'b0, divisor}) : rem_t[7:0];
        quo_nx = {quo[14:0], ge};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ready    <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            q        <= 16'd0;
            r        <= 8'd0;
            dbz      <= 1'b0;
            cnt      <= 4'd0;
            dividend <= 16'd0;
            divisor  <= 8'd0;
            rem      <= 8'd0;
            quo      <= 16'd0;
            zdiv     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        dividend <= a;
                        divisor  <= b;
                        rem      <= 8'd0;
                        quo      <= 16'd0;
                        cnt      <= 4'd0;
                        zdiv     <= (b == 8'd0);
                        state    <= WORK;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                WORK: begin
                    rem      <= rem_nx;
                    quo      <= quo_nx;
                    dividend <= {dividend[14:0], 1'b0};
                    cnt      <= cnt + 4'd1;
                    if (cnt == 4'd15) begin
                        state <= IDLE;
                        ready <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // Divide-by-zero still runs the full length but reports all-ones.
                        q     <= zdiv ? 16'hFFFF : quo_nx;
                        r     <= zdiv ? 8'hFF : rem_nx;
                        dbz   <= zdiv;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div.sv
// Directed bench for div: vector table plus hand-written busy, back-to-back and reset sequences.
module tb_div;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        ready;
    logic        busy;
    logic        done;
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        logic        dbz;
    } vec_t;

    vec_t vecs[9];

    div dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .q     (q),
        .r     (r),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " ready"}, 32'(ready), 32'd1);
        check({tag, " busy"},  32'(busy),  32'd0);
        check({tag, " done"},  32'(done),  32'd0);
        check({tag, " q"},     32'(q),     32'd0);
        check({tag, " r"},     32'(r),     32'd0);
        check({tag, " dbz"},   32'(dbz),   32'd0);
    endtask

    // One complete operation with accept, latency, result and done-width checks.
    task automatic run_div(input logic [15:0] ta, input logic [7:0] tb_b,
                           input logic [15:0] eq, input logic [7:0] er, input logic ed,
                           input string tag);
        int got;
        @(negedge clk);
        a = ta; b = tb_b; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check({tag, " accept busy"},  32'(busy),  32'd1);
        check({tag, " accept ready"}, 32'(ready), 32'd0);
        got = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = n;
                break;
            end
        end
        check({tag, " latency"}, 32'(got), 32'd16);
        check({tag, " q"},   32'(q),   32'(eq));
        check({tag, " r"},   32'(r),   32'(er));
        check({tag, " dbz"}, 32'(dbz), 32'(ed));
        check({tag, " done ready"}, 32'(ready), 32'd1);
        check({tag, " done busy"},  32'(busy),  32'd0);
        @(posedge clk);
        #1;
        check({tag, " done width"}, 32'(done), 32'd0);
    endtask

    initial begin
        int first_done;
        int done_cnt;
        int done_at[2];

        vecs[0] = '{a: 16'd1000,  b: 8'd7,   q: 16'd142,   r: 8'd6,   dbz: 1'b0};
        vecs[1] = '{a: 16'd65535, b: 8'd255, q: 16'd257,   r: 8'd0,   dbz: 1'b0};
        vecs[2] = '{a: 16'd65535, b: 8'd1,   q: 16'd65535, r: 8'd0,   dbz: 1'b0};
        vecs[3] = '{a: 16'd5,     b: 8'd9,   q: 16'd0,     r: 8'd5,   dbz: 1'b0};
        vecs[4] = '{a: 16'd1234,  b: 8'd0,   q: 16'hFFFF,  r: 8'hFF,  dbz: 1'b1};
        vecs[5] = '{a: 16'd10,    b: 8'd3,   q: 16'd3,     r: 8'd1,   dbz: 1'b0};
        vecs[6] = '{a: 16'd65535, b: 8'd2,   q: 16'd32767, r: 8'd1,   dbz: 1'b0};
        vecs[7] = '{a: 16'd0,     b: 8'd5,   q: 16'd0,     r: 8'd0,   dbz: 1'b0};
        vecs[8] = '{a: 16'd65534, b: 8'd254, q: 16'd258,   r: 8'd2,   dbz: 1'b0};

        rst = 1'b1; start = 1'b0; a = 16'd0; b = 8'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("reset");

        for (int i = 0; i < 9; i++) begin
            run_div(vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r, vecs[i].dbz, $sformatf("vec%0d", i));
        end

        // Start pulse and operand changes during WORK must be ignored.
        @(negedge clk);
        a = 16'd200; b = 8'd10; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        first_done = -1;
        done_cnt = 0;
        for (int n = 1; n <= 40; n++) begin
            if (n == 3) begin start = 1'b1; a = 16'd9; b = 8'd3; end
            if (n == 4) begin start = 1'b0; a = 16'd77; b = 8'd2; end
            @(posedge clk);
            #1;
            if (done) begin
                done_cnt++;
                if (first_done < 0) first_done = n;
            end
        end
        check("busy-ignore done count", 32'(done_cnt), 32'd1);
        check("busy-ignore latency", 32'(first_done), 32'd16);
        check("busy-ignore q hold", 32'(q), 32'd20);
        check("busy-ignore r hold", 32'(r), 32'd0);
        check("busy-ignore ready", 32'(ready), 32'd1);

        // Start held high: accepts 17 cycles apart.
        @(negedge clk);
        a = 16'd100; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        done_cnt = 0;
        done_at[0] = -1; done_at[1] = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                if (done_cnt < 2) done_at[done_cnt] = n;
                done_cnt++;
                if (done_cnt == 1) begin
                    check("held first q", 32'(q), 32'd14);
                    check("held first r", 32'(r), 32'd2);
                    a = 16'd255; b = 8'd16;
                end else if (done_cnt == 2) begin
                    check("held second q", 32'(q), 32'd15);
                    check("held second r", 32'(r), 32'd15);
                    start = 1'b0;
                end
            end
            if (n == 17) begin
                check("held reaccept ready", 32'(ready), 32'd0);
                check("held done low after one cycle", 32'(done), 32'd0);
            end
        end
        check("held done count", 32'(done_cnt), 32'd2);
        check("held first done edge", 32'(done_at[0]), 32'd16);
        check("held second done edge", 32'(done_at[1]), 32'd33);
        start = 1'b0;

        // Reset after iteration 8 aborts with no done and clears outputs.
        @(negedge clk);
        a = 16'd1000; b = 8'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("pre-reset busy", 32'(busy), 32'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_reset_state("abort");
        done_cnt = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        check("abort no done", 32'(done_cnt), 32'd0);
        run_div(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, "after-abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
